alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Sequences dst <= dst OP src on the 32-bit data register file through the 16-bit registered ALU.
//   Sizes are byte, word or long. Long ops run as two 16-bit passes with carry/borrow chaining.
//   Sits between the instruction decoder (req side) and the ALU/data register file (datapath side).
//   Sole owner of the register-file ports and the ALU ports while busy.
// PARAMETERS
//   REG_SEL_W  3  register select width (8 data registers)
// PORTS
//   CLK        in   1   clock
//   RESET      in   1   reset, synchronous, active-high
//   req_valid  in   1   operation request
//   req_ready  out  1   high only in IDLE; accept on req_valid&&req_ready
//   req_op     in   2   00 ADD, 01 SUB (dst-src), 10 AND, 11 OR
//   req_size   in   2   00 byte, 01 word, 10 long, 11 reserved (treated as long)
//   req_src    in   3   source register
//   req_dst    in   3   destination register
//   rf_sel_a   out  3   read port A select (src)
//   rf_sel_b   out  3   read port B / write select (dst)
//   rf_rd_a    in   32  port A data, combinational from rf_sel_a
//   rf_rd_b    in   32  port B data, combinational from rf_sel_b
//   rf_we      out  1   write enable; writes rf_wdata to rf_sel_b at the CLK edge
//   rf_wdata   out  32  write data
//   alu_a      out  16  ALU operand A (dst half)
//   alu_b      out  16  ALU operand B (src half)
//   alu_op     out  2   ALU function, same coding as req_op
//   alu_cin    out  1   carry-in (ADD) / borrow-in (SUB)
//   alu_out    in   16  ALU result, valid 1 cycle after operands
//   alu_cout   in   1   carry-out / borrow-out, same timing as alu_out
//   done       out  1   1-cycle pulse in WB
//   flag_n     out  1   result MSB for the op size; updated in WB
//   flag_z     out  1   result == 0 for the op size; updated in WB
//   flag_c     out  1   carry/borrow; always 0 for AND/OR; updated in WB
// BEHAVIOUR
//   Reset values: all outputs 0, except req_ready=1 once RESET deasserts. state=IDLE.
//   States: IDLE -> FETCH -> LO -> (long: HI ->) WB -> IDLE.
//   IDLE: req_ready=1. On accept, latch op/size/src/dst, go to FETCH.
//   FETCH: rf_sel_a=src, rf_sel_b=dst. Capture rf_rd_a->opS and rf_rd_b->opD.
//   LO: alu_op=op, alu_cin=0.
//     word/long: alu_a=opD[15:0], alu_b=opS[15:0].
//     byte: alu_a={8'h00,opD[7:0]}, alu_b={8'h00,opS[7:0]}.
//     Next state: HI if long, else WB.
//   HI (long only): latch lo=alu_out and c0=alu_cout.
//     Drive alu_a=opD[31:16], alu_b=opS[31:16], alu_cin=c0 (forced 0 for AND/OR).
//   WB: rf_we=1, rf_sel_b=dst, done=1, flags update.
//     long: rf_wdata={alu_out, lo}, C=alu_cout.
//     word: rf_wdata={opD[31:16], alu_out}, C=alu_cout.
//     byte: rf_wdata={opD[31:8], alu_out[7:0]}, C=alu_out[8].
//   Latency from accept edge T: done at T+4 (long), T+3 (word/byte).
//   Throughput: next accept no earlier than the cycle after WB.
//   rf_we is never high outside WB, so no partial writes.
//   src==dst is legal; operands come from the FETCH snapshot.
//   req_valid while busy is ignored (ready=0). Requester holds the request until accepted.
//   RESET in any state: return to IDLE next edge, rf_we=0, done=0, flags cleared.
//     An in-flight op is dropped and its dst is unchanged.
//   Flags hold their value between ops. N and Z use bit 7/15/31 and the low 8/16/32 bits.
// TESTING
//   1. D0=1, D1=1, ADD.L src=0 dst=1 -> D1=0x00000002, done at T+4, N=Z=C=0.
//   2. ADD.L dst=0x0000FFFF, src=0x00000001 -> dst=0x00010000 (carry crosses halves), C=0.
//   3. SUB.W dst=0x12340000, src=0x00000001 -> dst=0x1234FFFF, N=1, C=1, done at T+3.
//   4. ADD.B dst=0xAAAAAAFF, src=0x00000001 -> dst=0xAAAAAA00, Z=1, C=1, upper 24 bits kept.
//   5. RESET pulsed during HI of ADD.L -> rf_we never high, dst unchanged.
//      req_ready=1 the cycle after RESET drops.
//   6. req_valid held high over two ops (AND.L then OR.L):
//      - second op accepted in the cycle after the first op's WB;
//      - req_ready=0 throughout the first op;
//      - both results correct.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences dst <= dst OP src over a 32-bit register file using a 16-bit registered ALU.
// Long operations take two ALU passes (low half, then high half) with carry/borrow chaining.
module alu_op_sequencer #(
  parameter int REG_SEL_W = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [1:0]           req_size,
  input  logic [REG_SEL_W-1:0] req_src,
  input  logic [REG_SEL_W-1:0] req_dst,
  output logic [REG_SEL_W-1:0] rf_sel_a,
  output logic [REG_SEL_W-1:0] rf_sel_b,
  input  logic [31:0]          rf_rd_a,
  input  logic [31:0]          rf_rd_b,
  output logic                 rf_we,
  output logic [31:0]          rf_wdata,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [1:0]           alu_op,
  output logic                 alu_cin,
  input  logic [15:0]          alu_out,
  input  logic                 alu_cout,
  output logic                 done,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LO,
    S_HI,
    S_WB
  } state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             op_reg;
  logic [1:0]             size_reg;
  logic [REG_SEL_W-1:0]   src_reg;
  logic [REG_SEL_W-1:0]   dst_reg;
  logic [31:0]            ops_reg;
  logic [31:0]            opd_reg;
  logic [15:0]            lo_reg;
  logic                   flag_n_reg, flag_z_reg, flag_c_reg;

  logic [31:0]            wb_data_next;
  logic                   flag_n_next, flag_z_next, flag_c_next;

  logic is_long, is_byte, is_arith;

  // Reserved size 2'b11 shares the long path because only bit 1 is inspected.
  assign is_long  = size_reg[1];
  assign is_byte  = (size_reg == 2'b00);
  assign is_arith = ~op_reg[1];

  assign flag_n = flag_n_reg;
  assign flag_z = flag_z_reg;
  assign flag_c = flag_c_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      size_reg   <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      ops_reg    <= '0;
      opd_reg    <= '0;
      lo_reg     <= '0;
      flag_n_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            op_reg   <= req_op;
            size_reg <= req_size;
            src_reg  <= req_src;
            dst_reg  <= req_dst;
          end
        end
        S_FETCH: begin
          ops_reg <= rf_rd_a;
          opd_reg <= rf_rd_b;
        end
        S_HI: lo_reg <= alu_out;
        S_WB: begin
          flag_n_reg <= flag_n_next;
          flag_z_reg <= flag_z_next;
          flag_c_reg <= flag_c_next;
        end
        default: ;
      endcase
    end
  end

  // Write-back data and flags; in WB the ALU holds the last pass result.
  always_comb begin
    wb_data_next = opd_reg;
    flag_n_next  = 1'b0;
    flag_z_next  = 1'b0;
    flag_c_next  = 1'b0;
    if (is_long) begin
      wb_data_next = {alu_out, lo_reg};
      flag_n_next  = alu_out[15];
      flag_z_next  = (alu_out == 16'h0000) && (lo_reg == 16'h0000);
      flag_c_next  = alu_cout;
    end else if (is_byte) begin
      wb_data_next = {opd_reg[31:8], alu_out[7:0]};
      flag_n_next  = alu_out[7];
      flag_z_next  = (alu_out[7:0] == 8'h00);
      flag_c_next  = alu_out[8];
    end else begin
      wb_data_next = {opd_reg[31:16], alu_out};
      flag_n_next  = alu_out[15];
      flag_z_next  = (alu_out == 16'h0000);
      flag_c_next  = alu_cout;
    end
    if (!is_arith) flag_c_next = 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rf_sel_a   = '0;
    rf_sel_b   = '0;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = '0;
    alu_cin    = 1'b0;
    done       = 1'b0;
    if (!RESET) begin
      case (state_reg)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_next = S_FETCH;
        end
        S_FETCH: begin
          rf_sel_a   = src_reg;
          rf_sel_b   = dst_reg;
          state_next = S_LO;
        end
        S_LO: begin
          alu_op = op_reg;
          if (is_byte) begin
            alu_a = {8'h00, opd_reg[7:0]};
            alu_b = {8'h00, ops_reg[7:0]};
          end else begin
            alu_a = opd_reg[15:0];
            alu_b = ops_reg[15:0];
          end
          state_next = is_long ? S_HI : S_WB;
        end
        S_HI: begin
          // Low-pass carry is on alu_cout this cycle and chains straight into the high pass.
          alu_op     = op_reg;
          alu_a      = opd_reg[31:16];
          alu_b      = ops_reg[31:16];
          alu_cin    = is_arith & alu_cout;
          state_next = S_WB;
        end
        S_WB: begin
          rf_we      = 1'b1;
          rf_sel_b   = dst_reg;
          rf_wdata   = wb_data_next;
          done       = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with behavioural register file and registered ALU.
module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_size;
  logic [2:0]  req_src;
  logic [2:0]  req_dst;
  logic [2:0]  rf_sel_a;
  logic [2:0]  rf_sel_b;
  logic [31:0] rf_rd_a;
  logic [31:0] rf_rd_b;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic        done;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;

  always #5 CLK = ~CLK;

  alu_op_sequencer #(.REG_SEL_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_src(req_src), .req_dst(req_dst),
    .rf_sel_a(rf_sel_a), .rf_sel_b(rf_sel_b), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .rf_we(rf_we), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .done(done), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c)
  );

  // Register file: combinational reads, writes at the clock edge; bench preloads share the port.
  logic [31:0] rf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge CLK) begin
    if (rf_we) rf[rf_sel_b] <= rf_wdata;
    if (pre_we) rf[pre_idx] <= pre_val;
  end
  assign rf_rd_a = rf[rf_sel_a];
  assign rf_rd_b = rf[rf_sel_b];

  logic [16:0] alu_res = '0;
  always @(posedge CLK) begin
    case (alu_op)
      2'b00:   alu_res <= {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
      2'b01:   alu_res <= {1'b0, alu_a} - {1'b0, alu_b} - {16'h0, alu_cin};
      2'b10:   alu_res <= {1'b0, alu_a & alu_b};
      default: alu_res <= {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_out  = alu_res[15:0];
  assign alu_cout = alu_res[16];

  typedef struct {
    string       name;
    logic [2:0]  dst;
    logic [31:0] val;
    logic        n, z, c;
    int          lat;
    bit          b2b;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   busy = 1'b0;
  int   last_done_edge = -100;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse, then checks the written register and flags.
  always begin
    exp_t e;
    int   acc;
    @(negedge CLK);
    if (RESET) begin
      busy = 1'b0;
      acc_q.delete();
    end else begin
      if (rf_we && !done) chk("rf_we_outside_wb", {31'h0, rf_we}, 32'h0);
      if (busy) chk("ready_low_while_busy", {31'h0, req_ready}, 32'h0);
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc + 1);
        busy = 1'b1;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", {31'h0, done}, 32'h0);
        end else begin
          e   = sb_q.pop_front();
          acc = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
          chk({e.name, "_latency"}, cyc + 1 - acc, e.lat);
          if (e.b2b) chk({e.name, "_accept_after_wb"}, acc, last_done_edge + 1);
          last_done_edge = cyc + 1;
          busy = 1'b0;
          @(posedge CLK);
          #1;
          chk({e.name, "_result"}, rf[e.dst], e.val);
          chk({e.name, "_N"}, {31'h0, flag_n}, {31'h0, e.n});
          chk({e.name, "_Z"}, {31'h0, flag_z}, {31'h0, e.z});
          chk({e.name, "_C"}, {31'h0, flag_c}, {31'h0, e.c});
          $display("txn %s dst=D%0d data=0x%08h NZC=%b%b%b", e.name, e.dst, rf[e.dst], flag_n, flag_z, flag_c);
        end
      end
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    @(posedge CLK);
    #1;
    pre_we  = 1'b0;
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [1:0] size,
                       input logic [2:0] src, input logic [2:0] dst, input logic [31:0] val,
                       input logic n, input logic z, input logic c, input int lat,
                       input bit b2b, input bit keep, input bit expect_done);
    exp_t e;
    int   w;
    bit   ok;
    e.name = name; e.dst = dst; e.val = val; e.n = n; e.z = z; e.c = c; e.lat = lat; e.b2b = b2b;
    if (expect_done) sb_q.push_back(e);
    req_op = op; req_size = size; req_src = src; req_dst = dst; req_valid = 1'b1;
    ok = 1'b0;
    for (w = 0; w < 50; w++) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_accept_timeout"}, 32'h0, 32'h1);
    @(posedge CLK);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    for (w = 0; w < 50 && sb_q.size() != 0; w++) @(posedge CLK);
    if (sb_q.size() != 0) begin
      chk("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; req_valid = 1'b0; req_op = '0; req_size = '0; req_src = '0; req_dst = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h0);
    chk("reset_rf_we", {31'h0, rf_we}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // ADD.L basic
    preload(3'd0, 32'h00000001);
    preload(3'd1, 32'h00000001);
    issue("add_l", 2'b00, 2'b10, 3'd0, 3'd1, 32'h00000002, 0, 0, 0, 4, 0, 0, 1);
    wait_idle();

    // ADD.L carry across halves
    preload(3'd2, 32'h0000FFFF);
    preload(3'd3, 32'h00000001);
    issue("add_l_carry", 2'b00, 2'b10, 3'd3, 3'd2, 32'h00010000, 0, 0, 0, 4, 0, 0, 1);
    wait_idle();

    // SUB.W borrow, upper half kept
    preload(3'd4, 32'h12340000);
    preload(3'd5, 32'h00000001);
    issue("sub_w", 2'b01, 2'b01, 3'd5, 3'd4, 32'h1234FFFF, 1, 0, 1, 3, 0, 0, 1);
    wait_idle();

    // ADD.B wraps to zero, upper 24 bits kept
    preload(3'd6, 32'hAAAAAAFF);
    preload(3'd7, 32'h00000001);
    issue("add_b", 2'b00, 2'b00, 3'd7, 3'd6, 32'hAAAAAA00, 0, 1, 1, 3, 0, 0, 1);
    wait_idle();

    // RESET during HI of ADD.L: op dropped, dst untouched, flags cleared
    preload(3'd2, 32'h11111111);
    preload(3'd3, 32'h22222222);
    issue("rst_mid", 2'b00, 2'b10, 3'd2, 3'd3, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_flags", {29'h0, flag_n, flag_z, flag_c}, 32'h0);
    repeat (4) @(negedge CLK);
    chk("rst_mid_dst_kept", rf[3], 32'h22222222);
    chk("rst_mid_no_done", {31'h0, done}, 32'h0);
    $display("txn rst_mid dst=D3 data=0x%08h", rf[3]);

    // AND.L then OR.L back to back with req_valid held
    preload(3'd0, 32'hF0F0FF00);
    preload(3'd1, 32'h0FF0F0F0);
    issue("and_l", 2'b10, 2'b10, 3'd0, 3'd1, 32'h00F0F000, 0, 0, 0, 4, 0, 1, 1);
    issue("or_l", 2'b11, 2'b10, 3'd0, 3'd1, 32'hF0F0FF00, 1, 0, 0, 4, 1, 0, 1);
    wait_idle();

    // SUB.L borrow across halves
    preload(3'd2, 32'h00010000);
    preload(3'd3, 32'h00000001);
    issue("sub_l_borrow", 2'b01, 2'b10, 3'd3, 3'd2, 32'h0000FFFF, 0, 0, 0, 4, 0, 0, 1);
    wait_idle();

    // SUB.B negative result with borrow
    preload(3'd4, 32'h12345600);
    preload(3'd5, 32'h00000001);
    issue("sub_b", 2'b01, 2'b00, 3'd5, 3'd4, 32'h123456FF, 1, 0, 1, 3, 0, 0, 1);
    wait_idle();

    // src == dst, reserved size acts as long: 0x80000000 + itself
    preload(3'd7, 32'h80000000);
    issue("add_rsv_same", 2'b00, 2'b11, 3'd7, 3'd7, 32'h00000000, 0, 1, 1, 4, 0, 0, 1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
